// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM states shared by the multi-cycle ALU
package alu_pkg;
  localparam logic [3:0] OP_LBI  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SRX  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_MULH = 4'b1001;
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} alu_state_t;
endpackage

// File: rtl/mul_iter.sv
// mul_iter: radix-2 shift-add unsigned multiplier, one partial product per step
module mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic [2*WIDTH-1:0] prod_nxt
);
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH:0]     sum;
  // add the multiplicand into the upper half when the multiplier LSB is set, then shift right
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    prod_nxt = {sum, acc_q[WIDTH-1:1]};
  end
  // accumulator holds {partial high, remaining multiplier bits}; start reloads it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      m_q   <= '0;
    end else if (start) begin
      acc_q <= {{WIDTH{1'b0}}, b};
      m_q   <= a;
    end else if (step) begin
      acc_q <= prod_nxt;
    end
  end
  assign prod = acc_q;
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with single-cycle logic/arith ops, iterative multiply and valid/ready handshakes
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int SW = $clog2(WIDTH);
  alu_state_t state_q, state_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic                 mulh_q, mulh_d;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [3:0]           flg_q, flg_d;
  logic [WIDTH-1:0]     alu_res, add_a, mul_res;
  logic signed [WIDTH-1:0] sra;
  logic [WIDTH:0]       sum;
  logic [3:0]           alu_flg, mul_flg;
  logic                 alu_c, alu_v, legal, is_sub;
  logic [2*WIDTH-1:0]   prod, prod_nxt, mul_p;
  logic                 mul_start, mul_step, accept, is_mul;

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(mul_start), .step(mul_step),
    .a(src1), .b(src2), .prod(prod), .prod_nxt(prod_nxt)
  );

  assign in_ready = (state_q == IDLE) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL) || (op == OP_MULH);

  // single-cycle datapath; SUB reuses the adder as ~src1 + src2 + 1
  always_comb begin
    is_sub  = op == OP_SUB;
    add_a   = is_sub ? ~src1 : src1;
    sum     = {1'b0, add_a} + {1'b0, src2} + {{WIDTH{1'b0}}, is_sub};
    sra     = $signed(src1) >>> src2[SW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    legal   = 1'b1;
    case (op)
      OP_LBI:  alu_res = src2[8] ? {{(WIDTH-8){src2[7]}}, src2[7:0]} : {src1[WIDTH-9:0], src2[7:0]};
      OP_XOR:  alu_res = src1 ^ src2;
      OP_OR:   alu_res = src1 | src2;
      OP_AND:  alu_res = src1 & src2;
      OP_SLL:  alu_res = src1 << src2[SW-1:0];
      OP_SRX:  alu_res = src2[SW] ? sra : src1 >> src2[SW-1:0];
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (add_a[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1]);
      end
      default: legal = 1'b0;
    endcase
    alu_flg = '0;
    if (legal) begin
      alu_flg[FLG_Z] = ~|alu_res;
      alu_flg[FLG_N] = alu_res[WIDTH-1];
      alu_flg[FLG_C] = alu_c;
      alu_flg[FLG_V] = alu_v;
    end
  end

  // multiply result: in BUSY the final step is still in flight, in HOLD the product is settled
  always_comb begin
    mul_p          = (state_q == HOLD) ? prod : prod_nxt;
    mul_res        = mulh_q ? mul_p[2*WIDTH-1:WIDTH] : mul_p[WIDTH-1:0];
    mul_flg        = '0;
    mul_flg[FLG_Z] = ~|mul_res;
    mul_flg[FLG_N] = mul_res[WIDTH-1];
    mul_flg[FLG_C] = !mulh_q && (|mul_p[2*WIDTH-1:WIDTH]);
  end

  // FSM next state and output-slot loading; the slot drains whenever out_ready is seen
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mulh_d    = mulh_q;
    valid_d   = valid_q && !out_ready;
    res_d     = res_q;
    flg_d     = flg_q;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (is_mul) begin
          state_d   = BUSY;
          cnt_d     = SW'(WIDTH-1);
          mulh_d    = op == OP_MULH;
          mul_start = 1'b1;
        end else begin
          valid_d = 1'b1;
          res_d   = alu_res;
          flg_d   = alu_flg;
        end
      end
      BUSY: begin
        mul_step = 1'b1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = (!valid_q || out_ready) ? IDLE : HOLD;
          if (!valid_q || out_ready) begin
            valid_d = 1'b1;
            res_d   = mul_res;
            flg_d   = mul_flg;
          end
        end
      end
      HOLD: if (valid_q && out_ready) begin
        state_d = IDLE;
        valid_d = 1'b1;
        res_d   = mul_res;
        flg_d   = mul_flg;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mulh_q  <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mulh_q  <= mulh_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = res_q;
  assign flags     = flg_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors with a scoreboard model for alu_mc at WIDTH 16 plus a WIDTH 32 multiply check
module tb_alu_mc;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [3:0] op, flags;
  logic [15:0] src1, src2, result;
  logic v32, r32, ov32, or32;
  logic [3:0] op32, fl32;
  logic [31:0] a32, b32, res32;
  int n_vec = 0, n_err = 0, stalls = 0;
  logic [19:0] q[$];

  alu_mc #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );
  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .op(op32),
    .src1(a32), .src2(b32), .out_valid(ov32), .out_ready(or32),
    .result(res32), .flags(fl32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: {V,C,N,Z,result} straight from the operation definitions, using wide integer arithmetic
  function automatic logic [19:0] model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, s;
    longint unsigned p;
    logic [15:0] r;
    logic v, c, ok;
    sa = $signed(a);
    sb = $signed(b);
    p  = longint'(a) * longint'(b);
    r = 16'h0; v = 1'b0; c = 1'b0; ok = 1'b1;
    case (o)
      4'd0: r = b[8] ? ((b[7] ? 16'hFF00 : 16'h0000) | {8'h00, b[7:0]}) : {a[7:0], b[7:0]};
      4'd1: r = a ^ b;
      4'd4: r = a | b;
      4'd5: r = a & b;
      4'd2: r = a << b[3:0];
      4'd3: begin
        if (b[4]) begin
          s = sa >>> b[3:0];
          r = s[15:0];
        end else r = a >> b[3:0];
      end
      4'd6: begin
        s = int'(a) + int'(b);
        r = s[15:0];
        c = s > 65535;
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'd7: begin
        r = b - a;
        c = b >= a;
        v = (sb - sa > 32767) || (sb - sa < -32768);
      end
      4'd8: begin
        r = p[15:0];
        c = p[31:16] != 0;
      end
      4'd9: r = p[31:16];
      default: ok = 1'b0;
    endcase
    return ok ? {v, c, r[15], r == 16'h0, r} : 20'h0;
  endfunction

  // scoreboard: expected outputs queue up on acceptance and are checked every cycle the slot is valid
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (out_valid) begin
        if (q.size() == 0) chk("sb_empty", 0, 1);
        else begin
          chk("sb", {flags, result}, q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(op, src1, src2));
    end
  end

  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    int k = 0;
    in_valid = 1'b1; op = o; src1 = a; src2 = b;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    stalls += k;
    if (!in_ready) chk("accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n, output logic bad);
    n = 0; bad = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
  endtask

  typedef struct {logic [3:0] o; logic [15:0] a, b, r; logic [3:0] f;} vec_t;
  vec_t tbl[13] = '{
    '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010},
    '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b0101},
    '{OP_SRX, 16'h8000, 16'h0013, 16'hF000, 4'b0010},
    '{OP_LBI, 16'h1234, 16'h0056, 16'h3456, 4'b0000},
    '{OP_LBI, 16'h1234, 16'h0180, 16'hFF80, 4'b0010},
    '{OP_XOR, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000},
    '{OP_OR,  16'hF000, 16'h000F, 16'hF00F, 4'b0010},
    '{OP_SLL, 16'h0003, 16'h0004, 16'h0030, 4'b0000},
    '{OP_SRX, 16'h8000, 16'h0003, 16'h1000, 4'b0000},
    '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101},
    '{OP_SUB, 16'h0001, 16'h0000, 16'hFFFF, 4'b0010},
    '{4'b1010, 16'h1234, 16'h5678, 16'h0000, 4'b0000},
    '{OP_AND, 16'h00FF, 16'h0F0F, 16'h000F, 4'b0000}
  };

  initial begin
    int n, cyc;
    logic bad;
    logic [31:0] hold_r;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; src1 = '0; src2 = '0; out_ready = 1'b1;
    v32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; or32 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("model_add", model(OP_ADD, 16'h7FFF, 16'h0001), 20'hA8000);
    chk("model_mul", model(OP_MUL, 16'hFFFF, 16'h0002), 20'h6FFFE);
    chk("model_mulh", model(OP_MULH, 16'hFFFF, 16'h0002), 20'h00001);
    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].o, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_result", i), result, tbl[i].r);
      chk($sformatf("vec%0d_flags", i), flags, tbl[i].f);
    end
    chk("throughput_stalls", stalls, 0);
    issue(OP_MUL, 16'hFFFF, 16'h0002);
    wait_out(n, bad);
    chk("mul_latency", n, 16);
    chk("mul_busy_ready", bad, 0);
    chk("mul_result", result, 16'hFFFE);
    chk("mul_flags", flags, 4'b0110);
    issue(OP_MULH, 16'hFFFF, 16'h0002);
    wait_out(n, bad);
    chk("mulh_latency", n, 16);
    chk("mulh_busy_ready", bad, 0);
    chk("mulh_result", result, 16'h0001);
    chk("mulh_flags", flags, 4'b0000);
    issue(OP_MUL, 16'h00FF, 16'h0101);
    out_ready = 1'b0;
    wait_out(n, bad);
    chk("bp_latency", n, 16);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 16'hFFFF);
      chk("bp_flags", flags, 4'b0010);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drained", out_valid, 0);
    v32 = 1'b1; op32 = OP_MULH; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF;
    @(negedge clk);
    chk("w32_in_ready", r32, 1);
    @(posedge clk); #1;
    v32 = 1'b0; a32 = '0; b32 = '0;
    cyc = 0;
    while (!ov32 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w32_latency", cyc, 32);
    chk("w32_result", res32, 32'hFFFFFFFE);
    chk("w32_flags", fl32, 4'b0010);
    hold_r = res32;
    repeat (2) @(posedge clk);
    #1;
    chk("w32_hold", {ov32, r32, res32}, {2'b10, hold_r});
    or32 = 1'b1;
    @(posedge clk); #1;
    chk("w32_drained", ov32, 0);
    issue(OP_MUL, 16'h1234, 16'h5678);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", flags, 0);
    chk("abort_in_ready", in_ready, 1);
    issue(OP_AND, 16'hF0F0, 16'h0FF0);
    chk("post_and_result", result, 16'h00F0);
    chk("post_and_flags", flags, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
